// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Definitions shared by the DVP camera transmitter and its pattern generator:
//   - cam_state_t : frame-sequencer states, in the order they are visited
//   - RGB_*       : the eight RGB565 colour-bar values, left to right
//   - bar_rgb()   : maps a bar index (0..7) to its RGB565 colour
// ---------------------------------------------------------------------------
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } cam_state_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// ---------------------------------------------------------------------------
// dvp_pattern_gen
// Purely combinational test-pattern source for the DVP transmitter.
//   x       in  16  pixel index within the active line
//   y       in  16  active line index
//   pattern in   1  0 = eight vertical colour bars, 1 = ramp {y[7:0], x[7:0]}
//   pixel   out 16  RGB565 pixel value
// Parameter H_ACTIVE sets the bar width (H_ACTIVE/8 pixels per bar).
// ---------------------------------------------------------------------------
module dvp_pattern_gen #(
    parameter int H_ACTIVE = 640
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        pattern,
    output logic [15:0] pixel
);
    import cam_pkg::*;

    // Narrow rasters would give a zero-width bar; fall back to one pixel.
    localparam int BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

    // The bar index is the number of bar boundaries at or left of x. This
    // avoids a divider and saturates at bar 7 when H_ACTIVE is not a
    // multiple of eight.
    logic [6:0] past_edge;

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_edge
            assign past_edge[gi-1] = (x >= 16'(gi * BAR_W));
        end
    endgenerate

    logic [2:0] bar_idx;

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar_idx = bar_idx + {2'b00, past_edge[i]};
        end
    end

    assign pixel = pattern ? {y[7:0], x[7:0]} : bar_rgb(bar_idx);

    // Only the low byte of the line index contributes to the ramp.
    logic unused_y_hi;
    assign unused_y_hi = ^y[15:8];

endmodule

// File: rtl/dvp_cam_tx.sv
// ---------------------------------------------------------------------------
// dvp_cam_tx
// DVP (parallel camera) transmitter: emits vsync/href framing and an 8-bit
// byte stream (RGB565, high byte first) on the pixel clock.
//
// Ports
//   i_clk        in   1  pixel clock, all outputs launch on its rising edge
//   i_rstn       in   1  asynchronous active-low reset
//   i_en         in   1  run enable (a started frame always completes)
//   i_pattern    in   1  0 = colour bars, 1 = ramp; sampled on the o_sof cycle
//   i_pix_data   in  16  external RGB565 pixel
//   i_pix_valid  in   1  i_pix_data valid
//   o_pix_rd     out  1  pops i_pix_data in the same cycle
//   o_vsync      out  1  vertical sync, active high
//   o_href       out  1  line valid, active high
//   o_data       out  8  DVP byte, 8'h00 while o_href is low
//   o_sof        out  1  first cycle of a frame (first vsync cycle)
//   o_eof        out  1  cycle carrying the last byte of the frame
//   o_underflow  out  1  sticky external-pixel starvation flag
//   o_frame_cnt  out 16  completed-frame count, wraps
//
// Build option: define DVP_CAM_TX_EXT_PIXEL_EN to take active pixels from
// i_pix_data/i_pix_valid instead of the internal pattern generator.
// ---------------------------------------------------------------------------
module dvp_cam_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic        i_pattern,
    input  logic [15:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_rd,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_underflow,
    output logic [15:0] o_frame_cnt
);
    import cam_pkg::*;

    localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;

    localparam logic [15:0] H_LAST      = 16'(LINE_CLKS - 1);
    localparam logic [15:0] HREF_CLKS   = 16'(2 * H_ACTIVE);
    localparam logic [15:0] EOF_H       = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] PRE_EOF_H   = 16'(2 * H_ACTIVE - 2);
    localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VBACK_LAST  = 16'(V_BACK - 1);
    localparam logic [15:0] ACTIVE_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] VFRONT_LAST = 16'(V_FRONT - 1);

    cam_state_t  state_reg, state_next, state_after;
    logic [15:0] h_cnt_reg, h_cnt_next;   // clock within the line period
    logic [15:0] v_cnt_reg, v_cnt_next;   // line period within the state
    logic [15:0] lines_last;
    logic [15:0] frame_cnt_reg;

    logic frame_sof;
    logic href_on;
    logic hi_byte;
    logic last_line;
    logic frame_eof;

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= IDLE;
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state: every non-idle state is a whole number of line periods.
    // Zero-length VBACK/VFRONT are skipped when choosing the successor.
    // ------------------------------------------------------------------
    always_comb begin
        lines_last  = '0;
        state_after = IDLE;
        case (state_reg)
            VSYNC: begin
                lines_last  = VSYNC_LAST;
                state_after = (V_BACK > 0) ? VBACK : ACTIVE;
            end
            VBACK: begin
                lines_last  = VBACK_LAST;
                state_after = ACTIVE;
            end
            ACTIVE: begin
                lines_last  = ACTIVE_LAST;
                if (V_FRONT > 0) begin
                    state_after = VFRONT;
                end else begin
                    state_after = i_en ? VSYNC : IDLE;
                end
            end
            VFRONT: begin
                lines_last  = VFRONT_LAST;
                state_after = i_en ? VSYNC : IDLE;
            end
            default: begin
                lines_last  = '0;
                state_after = IDLE;
            end
        endcase

        state_next = state_reg;
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;

        if (state_reg == IDLE) begin
            h_cnt_next = '0;
            v_cnt_next = '0;
            if (i_en) begin
                state_next = VSYNC;
            end
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            if (v_cnt_reg == lines_last) begin
                v_cnt_next = '0;
                state_next = state_after;
            end else begin
                v_cnt_next = v_cnt_reg + 16'd1;
            end
        end else begin
            h_cnt_next = h_cnt_reg + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Framing decode from the registered position
    // ------------------------------------------------------------------
    always_comb begin
        frame_sof = 1'b0;
        href_on   = 1'b0;
        last_line = 1'b0;
        frame_eof = 1'b0;
        hi_byte   = ~h_cnt_reg[0];
        o_vsync   = 1'b0;

        if (state_reg == VSYNC) begin
            o_vsync   = 1'b1;
            frame_sof = (h_cnt_reg == 16'd0) && (v_cnt_reg == 16'd0);
        end
        if (state_reg == ACTIVE) begin
            href_on   = (h_cnt_reg < HREF_CLKS);
            last_line = (v_cnt_reg == ACTIVE_LAST);
            frame_eof = last_line && (h_cnt_reg == EOF_H);
        end
    end

    assign o_href = href_on;
    assign o_sof  = frame_sof;
    assign o_eof  = frame_eof;

    // The count advances on the edge that opens the o_eof cycle so the new
    // value is already visible while o_eof is high.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            frame_cnt_reg <= '0;
        end else if (last_line && (h_cnt_reg == PRE_EOF_H)) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_reg;

    // ------------------------------------------------------------------
    // Pixel source
    // ------------------------------------------------------------------
`ifdef DVP_CAM_TX_EXT_PIXEL_EN
    logic [15:0] ext_pixel;
    logic [7:0]  low_byte_reg;
    logic        underflow_reg;
    logic        pop;

    // One pop per pixel, on its high-byte cycle; a starved pop sends black.
    assign pop       = href_on && hi_byte;
    assign ext_pixel = i_pix_valid ? i_pix_data : 16'h0000;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            low_byte_reg  <= '0;
            underflow_reg <= 1'b0;
        end else if (pop) begin
            low_byte_reg <= ext_pixel[7:0];
            if (!i_pix_valid) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        o_data = 8'h00;
        if (href_on) begin
            o_data = hi_byte ? ext_pixel[15:8] : low_byte_reg;
        end
    end

    assign o_pix_rd    = pop;
    assign o_underflow = underflow_reg;

    logic unused_pattern;
    assign unused_pattern = i_pattern;
`else
    logic        pattern_reg;
    logic [15:0] pix_x;
    logic [15:0] gen_pixel;

    // Pattern choice is frozen at the start of each frame.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pattern_reg <= 1'b0;
        end else if (frame_sof) begin
            pattern_reg <= i_pattern;
        end
    end

    // Two clocks per pixel, so the pixel index is the line clock halved.
    assign pix_x = {1'b0, h_cnt_reg[15:1]};

    dvp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .x       (pix_x),
        .y       (v_cnt_reg),
        .pattern (pattern_reg),
        .pixel   (gen_pixel)
    );

    always_comb begin
        o_data = 8'h00;
        if (href_on) begin
            o_data = hi_byte ? gen_pixel[15:8] : gen_pixel[7:0];
        end
    end

    assign o_pix_rd    = 1'b0;
    assign o_underflow = 1'b0;

    logic unused_ext;
    assign unused_ext = ^{i_pix_data, i_pix_valid};
`endif

endmodule

// File: tb/tb_dvp_cam_tx.sv
// ---------------------------------------------------------------------------
// tb_dvp_cam_tx
// Directed bench for dvp_cam_tx on a small raster (8x2 active, 4 blank
// clocks, one line each of vsync / back / front porch: 20-clock lines,
// 100-clock frames). Expected bytes for a frame are queued when the frame's
// stimulus is chosen and popped as the DUT raises o_href.
// ---------------------------------------------------------------------------
module tb_dvp_cam_tx;

    localparam int HA    = 8;
    localparam int VA    = 2;
    localparam int HB    = 4;
    localparam int VSL   = 1;
    localparam int VBK   = 1;
    localparam int VFR   = 1;
    localparam int LINE  = 2 * HA + HB;                 // 20
    localparam int FRAME = (VSL + VBK + VA + VFR) * LINE; // 100
    localparam int ACT0  = (VSL + VBK) * LINE;          // first active clock
    localparam int EOFP  = ACT0 + (VA - 1) * LINE + 2 * HA - 1;

`ifdef DVP_CAM_TX_EXT_PIXEL_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rstn      = 1'b0;
    logic        en        = 1'b0;
    logic        pattern   = 1'b0;
    logic [15:0] pix_data  = 16'h0000;
    logic        pix_valid = 1'b0;

    logic        pix_rd, vsync, href, sof, eof, underflow;
    logic [7:0]  data;
    logic [15:0] frame_cnt;

    int          errors  = 0;
    int          checks  = 0;
    int          fc      = 0;
    bit          exp_uf  = 1'b0;
    int          frame_no = 0;
    logic [7:0]  exp_q [$];

    dvp_cam_tx #(
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .H_BLANK     (HB),
        .VSYNC_LINES (VSL),
        .V_BACK      (VBK),
        .V_FRONT     (VFR)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_en        (en),
        .i_pattern   (pattern),
        .i_pix_data  (pix_data),
        .i_pix_valid (pix_valid),
        .o_pix_rd    (pix_rd),
        .o_vsync     (vsync),
        .o_href      (href),
        .o_data      (data),
        .o_sof       (sof),
        .o_eof       (eof),
        .o_underflow (underflow),
        .o_frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] bar(input int x);
        case (x)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Pixel the bench offers for pixel k of a frame when the external
    // source is in use.
    function automatic logic [15:0] ext_pix(input int k);
        return {8'(8'h40 + k), 8'(8'hA0 + k)};
    endfunction

    // Pixel index for frame position q, or -1 outside href.
    function automatic int pix_index(input int q);
        int hp;
        if (q < ACT0 || q >= ACT0 + VA * LINE) return -1;
        hp = (q - ACT0) % LINE;
        if (hp >= 2 * HA) return -1;
        return ((q - ACT0) / LINE) * HA + hp / 2;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit pat, input int starve);
        logic [15:0] px;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                if (EXT) px = ((y * HA + x) == starve) ? 16'h0000 : ext_pix(y * HA + x);
                else     px = pat ? {8'(y), 8'(x)} : bar(x);
                exp_q.push_back(px[15:8]);
                exp_q.push_back(px[7:0]);
            end
        end
    endtask

    // Inputs sampled at the end of cycle p, plus the pixel offered in p+1.
    task automatic set_inputs(input int p, input bit pat, input int drop_at, input int starve);
        int k;
        pattern = (p == 0) ? pat : ~pat;
        en      = !(drop_at >= 0 && p >= drop_at);
        k       = pix_index(p + 1);
        if (k < 0) begin
            pix_data  = 16'h0000;
            pix_valid = 1'b1;
        end else begin
            pix_data  = ext_pix(k);
            pix_valid = (k != starve);
        end
    endtask

    task automatic check_pos(input int p, input int starve);
        int         k;
        bit         href_e, hi_e;
        logic [7:0] eb;
        k      = pix_index(p);
        href_e = (k >= 0);
        hi_e   = (((p - ACT0) % LINE) % 2) == 0;
        if (p == EOFP) fc++;
        chk("sof", 16'(sof), 16'(p == 0));
        chk("vsync", 16'(vsync), 16'(p < VSL * LINE));
        chk("href", 16'(href), 16'(href_e));
        chk("eof", 16'(eof), 16'(p == EOFP));
        chk("frame_cnt", frame_cnt, 16'(fc));
        chk("pix_rd", 16'(pix_rd), 16'(EXT && href_e && hi_e));
        chk("underflow", 16'(underflow), 16'(exp_uf));
        if (href_e) begin
            chk("sb_nonempty", 16'(exp_q.size() > 0), 16'd1);
            if (exp_q.size() > 0) begin
                eb = exp_q.pop_front();
                chk("data", 16'(data), 16'(eb));
            end
        end else begin
            chk("data_blank", 16'(data), 16'd0);
        end
        if (EXT && href_e && hi_e && k == starve) exp_uf = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vsync"}, 16'(vsync), 16'd0);
        chk({tag, "_href"}, 16'(href), 16'd0);
        chk({tag, "_sof"}, 16'(sof), 16'd0);
        chk({tag, "_eof"}, 16'(eof), 16'd0);
        chk({tag, "_pix_rd"}, 16'(pix_rd), 16'd0);
        chk({tag, "_underflow"}, 16'(underflow), 16'd0);
        chk({tag, "_data"}, 16'(data), 16'd0);
        chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
    endtask

    task automatic do_reset();
        #3 rstn = 1'b0;
        #1 check_zero("rst_async");
        cyc();
        check_zero("rst_held");
        rstn = 1'b1;
        exp_q.delete();
        fc     = 0;
        exp_uf = 1'b0;
        $display("frame aborted by reset, scoreboard flushed");
    endtask

    task automatic run_frame(input bit pat, input int drop_at, input int starve, input int rst_at);
        int rd_cnt;
        rd_cnt = 0;
        en = 1'b1;
        push_frame(pat, starve);
        for (int p = 0; p < FRAME; p++) begin
            cyc();
            check_pos(p, starve);
            rd_cnt += int'(pix_rd);
            if (p == rst_at) begin
                do_reset();
                return;
            end
            set_inputs(p, pat, drop_at, starve);
        end
        chk("pix_rd_per_frame", 16'(rd_cnt), EXT ? 16'd16 : 16'd0);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);
        frame_no++;
        $display("frame %0d pattern=%0d en_drop=%0d frame_cnt=%0d", frame_no, pat, drop_at, frame_cnt);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk({tag, "_vsync"}, 16'(vsync), 16'd0);
            chk({tag, "_sof"}, 16'(sof), 16'd0);
            chk({tag, "_href"}, 16'(href), 16'd0);
            chk({tag, "_frame_cnt"}, frame_cnt, 16'(fc));
        end
        $display("%s: %0d idle cycles", tag, n);
    endtask

    initial begin
        rstn      = 1'b0;
        en        = 1'b0;
        pattern   = 1'b0;
        pix_data  = 16'hBEEF;
        pix_valid = 1'b1;
        repeat (3) cyc();
        check_zero("reset");
        rstn = 1'b1;
        idle_cycles(5, "idle_en0");

        run_frame(1'b0, -1, 2, -1);   // colour bars; third pixel starved
        run_frame(1'b1, -1, -1, -1);  // ramp, back-to-back
        run_frame(1'b0, 30, -1, -1);  // enable dropped mid-frame
        idle_cycles(10, "idle_after_drop");
        run_frame(1'b1, -1, -1, 45);  // reset mid-frame
        run_frame(1'b1, -1, -1, -1);  // restart right after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dvp_cam_tx.md
DVP_CAM_TX -- requirements
Module: dvp_cam_tx

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter H_BLANK, default 144: href-low clocks after each active line.
REQ-004 Parameter VSYNC_LINES, default 3: line periods with vsync high.
REQ-005 Parameters V_BACK, default 17, and V_FRONT, default 10: blank line periods before and after the active lines.
REQ-006 i_clk  in  1  pixel clock; all outputs launch on its rising edge; the consumer samples on the same clock.
REQ-007 i_rstn  in  1  asynchronous active-low reset.
REQ-008 i_en  in  1  run enable, level-sensitive.
REQ-009 i_pattern  in  1  pattern select: 0 = colour bars, 1 = ramp.
REQ-010 i_pix_data  in  16  external RGB565 pixel.
REQ-011 i_pix_valid  in  1  i_pix_data is valid.
REQ-012 o_pix_rd  out  1  pops i_pix_data in the same cycle.
REQ-013 o_vsync, o_href  out  1 each  DVP framing signals, active high.
REQ-014 o_data  out  8  DVP byte.
REQ-015 o_sof, o_eof  out  1 each  single-cycle frame markers.
REQ-016 o_underflow  out  1  sticky external-pixel starvation flag.
REQ-017 o_frame_cnt  out  16  completed-frame count.

Function
REQ-018 LINE_CLKS SHALL equal 2*H_ACTIVE+H_BLANK; every line period, blank or active, SHALL last LINE_CLKS cycles.
REQ-019 The FSM SHALL have states IDLE, VSYNC, VBACK, ACTIVE and VFRONT, visited in that order.
REQ-020 IDLE->VSYNC SHALL occur on the first edge with i_en=1; o_vsync SHALL be high on the following cycle, and o_sof SHALL pulse for that one cycle.
REQ-021 VSYNC SHALL last VSYNC_LINES*LINE_CLKS cycles with o_vsync=1 and o_href=0; VBACK SHALL last V_BACK*LINE_CLKS cycles with both signals low.
REQ-022 In ACTIVE, each line SHALL drive o_href=1 for 2*H_ACTIVE cycles, then o_href=0 for H_BLANK cycles, for V_ACTIVE lines.
REQ-023 Each pixel SHALL be sent as two bytes: pixel[15:8] first, then pixel[7:0].
REQ-024 o_data SHALL be 8'h00 whenever o_href=0.
REQ-025 o_eof SHALL pulse on the cycle carrying the last byte of the last active line.
REQ-026 o_frame_cnt SHALL increment on that same cycle and wrap from 16'hFFFF to 0.
REQ-027 VFRONT SHALL last V_FRONT*LINE_CLKS cycles; at its end the FSM SHALL go to VSYNC if i_en=1, otherwise to IDLE.
REQ-028 Deasserting i_en mid-frame SHALL NOT truncate the frame.
REQ-029 i_pattern SHALL be sampled only on the o_sof cycle and held for the whole frame.
REQ-030 Colour bars: x/(H_ACTIVE/8) SHALL select, in order, FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-031 Ramp: pixel SHALL equal {y[7:0], x[7:0]}, where x is the pixel index in the line and y is the active line index.
REQ-032 Zero-valued parameters for V_BACK or V_FRONT SHALL skip the corresponding state.

Reset
REQ-033 While i_rstn=0: FSM in IDLE; all counters 0; o_vsync, o_href, o_sof, o_eof, o_pix_rd and o_underflow = 0; o_data = 8'h00; o_frame_cnt = 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately, with no partial o_eof.

Configuration
REQ-035 With DVP_CAM_TX_EXT_PIXEL_EN defined, active pixels SHALL come from i_pix_data, with o_pix_rd=1 for one cycle on each high-byte cycle.
REQ-036 Under DVP_CAM_TX_EXT_PIXEL_EN, if i_pix_valid=0 when a pixel is needed, the pixel SHALL be 16'h0000 and o_underflow SHALL set, cleared only by reset.
REQ-037 Without the macro, the internal pattern SHALL be used; i_pix_data and i_pix_valid SHALL be ignored, and o_pix_rd and o_underflow SHALL be held at 0.

Structure
REQ-038 Shared package cam_pkg SHALL hold the FSM state enum and the eight RGB565 bar constants.
REQ-039 Pattern generation SHALL be a sub-module, dvp_pattern_gen, with inputs x, y and pattern and a 16-bit pixel output.

Verification (H_ACTIVE=8, V_ACTIVE=2, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; LINE_CLKS=20, frame=100 cycles)
REQ-040 i_en held high -> o_sof every 100 cycles; o_vsync high for exactly 20 cycles; href high 16 cycles / low 4 cycles, twice per frame; o_frame_cnt increments by 1 per frame.
REQ-041 i_pattern=0 -> line 0 bytes SHALL be FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
REQ-042 i_pattern=1 -> line 1, pixel 3 bytes SHALL be 01,03; o_data SHALL be 00 during blanking.
REQ-043 i_en dropped at cycle 30 of a frame -> that frame SHALL complete with o_eof; FSM SHALL then remain in IDLE with o_vsync=0.
REQ-044 i_rstn pulsed low at cycle 45 -> all outputs SHALL be 0 immediately; with i_en=1 after release, a new o_sof SHALL appear 1 cycle later.
REQ-045 With DVP_CAM_TX_EXT_PIXEL_EN and i_pix_valid=0 for the 3rd pixel -> bytes 00,00 for that pixel; o_underflow SHALL rise and stay 1; 16 o_pix_rd pulses per frame.
